// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter; one-cycle tick and sticky expired flag at underflow, optional auto-reload.
// Latency: every output is registered and reflects the inputs sampled on the previous rising clk edge.
// Backpressure: none; stop pauses counting with count held, a later start resumes from the held value.
// Optional build macro COUNTDOWN_PRESCALE_EN: decrement only every prescale+1 RUN cycles.
module countdown_timer #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic                  clear_expired,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  tick,
    output logic                  expired
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tick_nxt;
    logic             expired_nxt;
    logic             dec_en;   // this RUN cycle is allowed to decrement
    logic             psc_clr;  // load, stop or RUN entry restarts the prescaler

`ifdef COUNTDOWN_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_cnt;

    // A decrement slot opens each time the prescaler reaches the programmed divisor.
    always_comb begin
        dec_en = (psc_cnt == prescale);
    end

    // Prescaler only advances while running; any restart or leaving RUN parks it at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_cnt <= '0;
        end else if (psc_clr || (state_nxt != ST_RUN) || dec_en) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PRESCALE_W'(1);
        end
    end
`else
    // Without the divider every RUN cycle is a decrement slot.
    always_comb begin
        dec_en = 1'b1;
    end

    // prescale is kept on the port list so both builds share one pinout.
    logic unused_prescale;
    assign unused_prescale = ^{prescale, psc_clr};
`endif

    // Next-state and datapath selection; priority inside a cycle is load > stop > start > decrement.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        reload_nxt  = reload;
        tick_nxt    = 1'b0;
        expired_nxt = expired;
        psc_clr     = 1'b0;

        // Clearing is applied first so an underflow in the same cycle overrides it.
        if (clear_expired) begin
            expired_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (load) begin
                    count_nxt   = load_val;
                    reload_nxt  = load_val;
                    expired_nxt = 1'b0;
                end else if (!stop && start && (count != CNT_ZERO)) begin
                    // Starting from zero would underflow immediately, so it is ignored.
                    state_nxt = ST_RUN;
                    psc_clr   = 1'b1;
                end
            end

            ST_RUN: begin
                if (load) begin
                    count_nxt   = load_val;
                    reload_nxt  = load_val;
                    expired_nxt = 1'b0;
                    psc_clr     = 1'b1;
                    // A zero load cannot be counted down, so park in IDLE.
                    if (load_val == CNT_ZERO) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (stop) begin
                    state_nxt = ST_IDLE;
                    psc_clr   = 1'b1;
                end else if (dec_en) begin
                    if (count == CNT_ONE) begin
                        // Underflow: tick coincides with the count reaching 0 or reloading.
                        tick_nxt    = 1'b1;
                        expired_nxt = 1'b1;
                        if (auto_reload && (reload != CNT_ZERO)) begin
                            count_nxt = reload;
                        end else begin
                            count_nxt = CNT_ZERO;
                            state_nxt = ST_DONE;
                        end
                    end else if (count != CNT_ZERO) begin
                        count_nxt = count - CNT_ONE;
                    end else begin
                        // Never decrement through zero; a zero count in RUN just finishes.
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                count_nxt = CNT_ZERO;
                if (load) begin
                    count_nxt   = load_val;
                    reload_nxt  = load_val;
                    expired_nxt = 1'b0;
                    state_nxt   = ST_IDLE;
                end else if (clear_expired) begin
                    // Acknowledging the expiry re-arms the timer; start alone is ignored here.
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                count_nxt = CNT_ZERO;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            reload  <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            reload  <= reload_nxt;
            running <= (state_nxt == ST_RUN);
            tick    <= tick_nxt;
            expired <= expired_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios for countdown_timer with hand-computed expectations.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// The prescale scenario is only compiled when COUNTDOWN_PRESCALE_EN is defined.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] load_val = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        auto_reload = 1'b0;
    logic        clear_expired = 1'b0;
    logic [7:0]  prescale = '0;
    logic [31:0] count;
    logic        running;
    logic        tick;
    logic        expired;

    int checks = 0;
    int passed = 0;

    countdown_timer #(.WIDTH(32), .PRESCALE_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_val      (load_val),
        .start         (start),
        .stop          (stop),
        .auto_reload   (auto_reload),
        .clear_expired (clear_expired),
        .prescale      (prescale),
        .count         (count),
        .running       (running),
        .tick          (tick),
        .expired       (expired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({count, running, tick, expired} !== 35'd0)
            $display("FAIL reset_state: count=%0d running=%b tick=%b expired=%b, required all 0", count, running, tick, expired);
        else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        load_val = 32'd5; load = 1'b1; step(); load = 1'b0;
        checks++;
        if (count !== 32'd5 || running !== 1'b0)
            $display("FAIL oneshot_load: count=%0d running=%b, required 5/0", count, running);
        else passed++;
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (count !== 32'd5 || running !== 1'b1)
            $display("FAIL oneshot_start: count=%0d running=%b, required 5/1", count, running);
        else passed++;
        for (int e = 4; e >= 0; e--) begin
            step();
            checks++;
            if (count !== 32'(e) || tick !== (e == 0))
                $display("FAIL oneshot_count: count=%0d tick=%b, required %0d/%b", count, tick, e, (e == 0));
            else passed++;
        end
        checks++;
        if (running !== 1'b0 || expired !== 1'b1)
            $display("FAIL oneshot_done: running=%b expired=%b, required 0/1", running, expired);
        else passed++;
        // Start in DONE is ignored, tick does not repeat.
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (running !== 1'b0 || tick !== 1'b0 || count !== 32'd0 || expired !== 1'b1)
            $display("FAIL done_start_ignored: running=%b tick=%b count=%0d expired=%b, required 0/0/0/1", running, tick, count, expired);
        else passed++;
        clear_expired = 1'b1; step(); clear_expired = 1'b0;
        checks++;
        if (expired !== 1'b0 || running !== 1'b0)
            $display("FAIL done_clear: expired=%b running=%b, required 0/0", expired, running);
        else passed++;
    endtask

    task automatic test_auto_reload();
        logic [31:0] exp_cnt [10] = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3, 32'd2};
        logic        exp_tck [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_exp [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        auto_reload = 1'b1;
        load_val = 32'd3; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (count !== exp_cnt[i] || tick !== exp_tck[i] || expired !== exp_exp[i] || running !== 1'b1)
                $display("FAIL reload_seq[%0d]: count=%0d tick=%b expired=%b running=%b, required %0d/%b/%b/1",
                         i, count, tick, expired, running, exp_cnt[i], exp_tck[i], exp_exp[i]);
            else passed++;
        end
        // count is 2: the next edge is not an underflow, so the clear takes effect.
        clear_expired = 1'b1; step(); clear_expired = 1'b0;
        checks++;
        if (expired !== 1'b0 || count !== 32'd1 || tick !== 1'b0)
            $display("FAIL reload_clear: expired=%b count=%0d tick=%b, required 0/1/0", expired, count, tick);
        else passed++;
        // count is 1: clear in the underflow cycle loses to the underflow.
        clear_expired = 1'b1; step(); clear_expired = 1'b0;
        checks++;
        if (expired !== 1'b1 || tick !== 1'b1 || count !== 32'd3)
            $display("FAIL clear_vs_underflow: expired=%b tick=%b count=%0d, required 1/1/3", expired, tick, count);
        else passed++;
        stop = 1'b1; step(); stop = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic test_stop_resume();
        load_val = 32'd10; load = 1'b1; step(); load = 1'b0;
        checks++;
        if (expired !== 1'b0)
            $display("FAIL load_clears_expired: expired=%b, required 0", expired);
        else passed++;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        checks++;
        if (count !== 32'd7)
            $display("FAIL stop_pre: count=%0d, required 7", count);
        else passed++;
        stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (count !== 32'd7 || running !== 1'b0)
                $display("FAIL stop_hold[%0d]: count=%0d running=%b, required 7/0", i, count, running);
            else passed++;
        end
        stop = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (count !== 32'd7 || running !== 1'b1)
            $display("FAIL resume_start: count=%0d running=%b, required 7/1", count, running);
        else passed++;
        for (int e = 6; e >= 4; e--) begin
            step();
            checks++;
            if (count !== 32'(e) || running !== 1'b1)
                $display("FAIL resume_count: count=%0d running=%b, required %0d/1", count, running, e);
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        // In RUN at count 4: load beats stop and start.
        load_val = 32'd9; load = 1'b1; stop = 1'b1; start = 1'b1; step();
        load = 1'b0; stop = 1'b0; start = 1'b0;
        checks++;
        if (count !== 32'd9 || running !== 1'b1)
            $display("FAIL load_wins: count=%0d running=%b, required 9/1", count, running);
        else passed++;
        load_val = 32'd0; load = 1'b1; step(); load = 1'b0;
        checks++;
        if (count !== 32'd0 || running !== 1'b0)
            $display("FAIL load_zero_run: count=%0d running=%b, required 0/0", count, running);
        else passed++;
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (running !== 1'b0 || count !== 32'd0)
            $display("FAIL start_at_zero: running=%b count=%0d, required 0/0", running, count);
        else passed++;
    endtask

    task automatic test_reload_one();
        auto_reload = 1'b1;
        load_val = 32'd1; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== 32'd1 || tick !== 1'b1 || running !== 1'b1)
                $display("FAIL reload_one[%0d]: count=%0d tick=%b running=%b, required 1/1/1", i, count, tick, running);
            else passed++;
        end
        stop = 1'b1; step(); stop = 1'b0;
        auto_reload = 1'b0;
        checks++;
        if (tick !== 1'b0 || running !== 1'b0)
            $display("FAIL reload_one_stop: tick=%b running=%b, required 0/0", tick, running);
        else passed++;
    endtask

    task automatic test_async_reset();
        load_val = 32'd6; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        checks++;
        if (count !== 32'd4 || running !== 1'b1)
            $display("FAIL areset_pre: count=%0d running=%b, required 4/1", count, running);
        else passed++;
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({count, running, tick, expired} !== 35'd0)
            $display("FAIL areset_immediate: count=%0d running=%b tick=%b expired=%b, required all 0", count, running, tick, expired);
        else passed++;
        step();
        checks++;
        if (tick !== 1'b0 || count !== 32'd0)
            $display("FAIL areset_hold: tick=%b count=%0d, required 0/0", tick, count);
        else passed++;
        reset = 1'b0;
        step();
        checks++;
        if ({count, running, tick, expired} !== 35'd0)
            $display("FAIL areset_release: count=%0d running=%b tick=%b expired=%b, required all 0", count, running, tick, expired);
        else passed++;
    endtask

`ifdef COUNTDOWN_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] exp_cnt [6] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0};
        prescale = 8'd2;
        load_val = 32'd2; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (count !== exp_cnt[i] || tick !== (i == 5))
                $display("FAIL prescale[%0d]: count=%0d tick=%b, required %0d/%b", i, count, tick, exp_cnt[i], (i == 5));
            else passed++;
        end
        prescale = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_stop_resume();
        test_simultaneous();
        test_reload_one();
        test_async_reset();
`ifdef COUNTDOWN_PRESCALE_EN
        test_prescale();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
